elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
- Parametrised, handshaked successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Carries a data payload and a control payload between two stages under valid/ready flow control, so stalls propagate without losing instructions.
- A synchronous flush inserts bubbles for branch and hazard recovery.
- An optional skid entry gives full throughput with a registered in_ready.

Parameters:
DATA_W, 64, width of datapath payload (PC, operands, immediate, ALU result packed by instantiator)
CTRL_W, 8, width of control payload (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_ctl, ...)
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready pass-through

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream stage has a valid instruction
in_ready  output  1  this register can accept this cycle
in_data  input  DATA_W  upstream datapath payload
in_ctrl  input  CTRL_W  upstream control payload
out_valid  output  1  held instruction valid toward downstream
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  datapath payload to downstream
out_ctrl  output  CTRL_W  control payload; forced 0 when out_valid=0

Behaviour:
- Transfer rules: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready.
- Reset (reset=0, asynchronous):
  - all state cleared to EMPTY; main and skid data/ctrl = 0
  - out_valid=0, out_ctrl=0, out_data=0
  - in_ready=1 once reset deasserts (held 0 while reset asserted)
- out_data/out_ctrl come directly from the main entry register; no combinational path from in_* to out_*.
- Latency is 1 cycle from in-fire to out_valid when EMPTY. Sustained throughput is 1 transfer/cycle.
- SKID_EN=1, state machine over main_valid/skid_valid:
  - EMPTY: in-fire -> ONE, main<=in.
  - ONE, in-fire and out-fire: stay ONE, main<=in.
  - ONE, in-fire only: -> FULL, skid<=in.
  - ONE, out-fire only: -> EMPTY.
  - FULL: in_ready=0. Out-fire -> ONE, main<=skid. Skid contents are never reordered or dropped.
  - in_ready = (state != FULL) & ~flush. This is a register output except for the flush gating.
- SKID_EN=0, single entry:
  - in_ready = (~main_valid | out_ready) & ~flush
  - in-fire loads main
  - out-fire without in-fire clears main_valid
- Flush (highest priority, sampled at clock edge):
  - state -> EMPTY; out_ctrl=0 next cycle
  - no in-fire is possible in a flush cycle (in_ready=0), so a coincident in_valid is dropped
  - no out-fire is counted as a transfer in a flush cycle
- Boundary conditions:
  - out_ready toggling while FULL never loses the skid entry.
  - in_valid high with out_ready low for many cycles: at most 2 entries (SKID_EN=1) or 1 entry (SKID_EN=0) accepted, then in_ready=0.
  - Reset mid-transfer discards all entries; no partial payload appears after reset.
- Payload is captured whole: no width conversion, no sign extension; DATA_W and CTRL_W only size the registers.

Optional Feature:
- Macro: ELASTIC_PIPE_PERF_EN.
- When defined, adds two outputs, both reset to 0 by reset:
  - stall_count (32 bits): increments each cycle with out_valid=1 and out_ready=0; saturates at 0xFFFFFFFF.
  - flush_count (16 bits): increments each cycle flush=1 while at least one entry is valid; saturates at 0xFFFF.
- When undefined, these ports and their counters are absent and the port list is exactly as above.

Test Plan:
- Back-to-back streaming: SKID_EN=1, out_ready=1, in_data=0x10,0x11,0x12 on consecutive cycles -> out_data 0x10,0x11,0x12 one cycle later each, in_ready constant 1.
- Backpressure fill: in_valid=1 with 0xA0,0xA1,0xA2, out_ready=0 -> 0xA0,0xA1 accepted, in_ready=0 from cycle 3. Release out_ready -> 0xA0 then 0xA1 then 0xA2 in order, nothing dropped.
- Flush: FULL with 0xB0/0xB1, flush=1 with in_valid=1, in_data=0xB2 -> next cycle out_valid=0, out_ctrl=0, 0xB2 never emitted.
- SKID_EN=0 pass-through: main valid, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle and the new payload appears the next cycle. With out_ready=0 -> in_ready=0.
- Async reset mid-stream: reset=0 between clock edges while FULL -> out_valid=0, out_data=0 immediately, without waiting for a clock edge. After release, in_ready=1 and the first transfer has latency 1.
- Perf counters (ELASTIC_PIPE_PERF_EN defined): 5 cycles out_valid=1 with out_ready=0 -> stall_count=5. Two flushes while non-empty -> flush_count=2.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Handshaked pipeline register with optional two-entry skid buffer (SKID_EN).
// Optional stall/flush performance counters are enabled by defining ELASTIC_PIPE_PERF_EN.
module elastic_pipe_reg #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SKID_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef ELASTIC_PIPE_PERF_EN
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       stall_count,
    output logic [15:0]       flush_count
`else
    output logic [CTRL_W-1:0] out_ctrl
`endif
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              rdy_q;
    logic              main_valid;
    logic              in_fire;
    logic              out_fire;

    assign main_valid = (state_q != StEmpty);
    assign in_fire    = in_valid & in_ready;
    // A flush cycle never counts as a downstream transfer.
    assign out_fire   = main_valid & out_ready & ~flush;

    always_comb begin
        if (SKID_EN != 0) begin
            in_ready = rdy_q & ~flush & reset;
        end else begin
            in_ready = (~main_valid | out_ready) & ~flush & reset;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d     = StOne;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                StOne: begin
                    if (in_fire && (out_fire || SKID_EN == 0)) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = StFull;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_d     = StOne;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            rdy_q       <= (state_d != StFull);
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};

`ifdef ELASTIC_PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid && !out_ready && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush && main_valid && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule
